// File: rtl/slab_hit_collector_pkg.sv
// Shared constants for the Ray-AABB slab-test back end: FloPoCo 11_4 field
// layout, default comparator latency and ray tag width, plus the collector FSM states.
package slab_hit_collector_pkg;

    localparam int FP_W            = 18;
    localparam int FP_EXC_HI       = 17;
    localparam int FP_EXC_LO       = 16;
    localparam logic [1:0] FP_EXC_NORMAL = 2'b01;
    localparam int FP_SIGN_BIT     = 15;

    // Matches the greater_than instance: FPSub pipeline plus its output register.
    localparam int DEF_CMP_LATENCY = 3;
    localparam int DEF_ID_W        = 8;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

endpackage

// File: rtl/slab_hit_collector_hit_fifo.sv
// First-word-fall-through FIFO holding {ray id, hit} verdicts; exposes its
// occupancy so the collector can run credit-based flow control.
module hit_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == FULL) && !pop));

endmodule

// File: rtl/slab_hit_collector.sv
// Aligns greater_than results with their issue tags, ORs the slab-overlap
// bits of each ray and queues one hit/miss verdict per ray under credit control.
module slab_hit_collector
    import slab_hit_collector_pkg::*;
#(
    parameter int CMP_LATENCY = DEF_CMP_LATENCY,
    parameter int NCMP        = 9,
    parameter int ID_W        = DEF_ID_W,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmp_issue,
    input  logic            cmp_first,
    input  logic [ID_W-1:0] ray_id,
    input  logic            greater,
    output logic            cmp_ready,
    output logic            hit_valid,
    output logic            hit,
    output logic [ID_W-1:0] hit_id,
    input  logic            hit_ready,
    output logic            err
);

    localparam int CNT_W = (NCMP > 1) ? $clog2(NCMP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCMP - 1);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int U_W   = FC_W + 2;

    logic [CMP_LATENCY-1:0] dl_issue;
    logic [CMP_LATENCY-1:0] dl_first;
    logic [ID_W-1:0]        dl_id [CMP_LATENCY];

    logic            a_issue;
    logic            a_first;
    logic [ID_W-1:0] a_id;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic            acc;
    logic [ID_W-1:0] cur_id;
    logic            push_r;
    logic [ID_W:0]   push_data;

    logic            start;
    logic            pop;
    logic            fsm_push;
    logic            abandon;
    logic            err_event;
    logic [U_W-1:0]  inflight;
    logic [U_W-1:0]  inflight_next;
    logic [U_W-1:0]  used_next;
    logic [FC_W-1:0] fifo_count;
    logic [ID_W:0]   fifo_head;
    logic            fifo_valid;

    // Tag delay line: its tail lines up with the greater bit of the same compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_issue <= '0;
            dl_first <= '0;
            for (int i = 0; i < CMP_LATENCY; i++) begin
                dl_id[i] <= '0;
            end
        end else begin
            dl_issue[0] <= cmp_issue;
            dl_first[0] <= cmp_first;
            dl_id[0]    <= ray_id;
            for (int i = 1; i < CMP_LATENCY; i++) begin
                dl_issue[i] <= dl_issue[i-1];
                dl_first[i] <= dl_first[i-1];
                dl_id[i]    <= dl_id[i-1];
            end
        end
    end

    assign a_issue = dl_issue[CMP_LATENCY-1];
    assign a_first = dl_first[CMP_LATENCY-1];
    assign a_id    = dl_id[CMP_LATENCY-1];

    assign start     = cmp_issue && cmp_first;
    assign pop       = fifo_valid && hit_ready;
    assign abandon   = a_issue && a_first && (state == COLLECT);
    assign fsm_push  = a_issue && ((a_first && (NCMP == 1)) ||
                                   (!a_first && (state == COLLECT) && (cnt == LAST)));
    assign err_event = (a_issue && !a_first && (state == IDLE)) || abandon ||
                       (start && !cmp_ready);

    // A verdict waiting in push_r still owns its FIFO slot, so it is counted as occupancy.
    always_comb begin
        inflight_next = inflight + U_W'(start) - U_W'(fsm_push) - U_W'(abandon);
        used_next     = U_W'(fifo_count) + U_W'(push_r) - U_W'(pop) +
                        U_W'(fsm_push) + inflight_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight  <= '0;
            cmp_ready <= 1'b0;
        end else begin
            inflight  <= inflight_next;
            cmp_ready <= (used_next < U_W'(FIFO_DEPTH));
        end
    end

    // Per-ray collection FSM; a first-flagged compare always (re)starts a ray.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= 1'b0;
            cur_id    <= '0;
            push_r    <= 1'b0;
            push_data <= '0;
            err       <= 1'b0;
        end else begin
            push_r <= fsm_push;
            if (a_issue) begin
                if (a_first) begin
                    acc    <= greater;
                    cnt    <= CNT_W'(1);
                    cur_id <= a_id;
                    if (NCMP == 1) begin
                        push_data <= {a_id, !greater};
                        state     <= IDLE;
                    end else begin
                        state <= COLLECT;
                    end
                end else if (state == COLLECT) begin
                    acc <= acc | greater;
                    if (cnt == LAST) begin
                        push_data <= {cur_id, !(acc | greater)};
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
            if (err_event) begin
                err <= 1'b1;
            end
        end
    end

    hit_fifo #(
        .WIDTH (ID_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign hit_valid = fifo_valid;
    assign hit       = fifo_valid ? fifo_head[0] : 1'b0;
    assign hit_id    = fifo_valid ? fifo_head[ID_W:1] : '0;

endmodule

// File: tb/tb_slab_hit_collector.sv
// Bench for slab_hit_collector: directed scenarios plus randomized rays,
// checked against a per-ray OR model and a queue of expected verdicts.
module tb_slab_hit_collector;

    localparam int NCMP = 9;
    localparam int LAT  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmp_issue = 1'b0;
    logic       cmp_first = 1'b0;
    logic [7:0] ray_id = 8'h00;
    logic       greater = 1'b0;
    logic       hit_ready = 1'b0;
    logic       cmp_ready;
    logic       hit_valid;
    logic       hit;
    logic [7:0] hit_id;
    logic       err;

    int total = 0;
    int bad = 0;
    bit rand_mode = 1'b0;
    logic [LAT-1:0] gl = '0;

    logic [8:0] exp_q [$];
    bit         m_active;
    bit         m_err;
    bit         m_acc;
    logic [7:0] m_id;
    int         m_cnt;

    always #5 clk = ~clk;

    slab_hit_collector #(
        .CMP_LATENCY (LAT),
        .NCMP        (NCMP),
        .ID_W        (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_issue (cmp_issue),
        .cmp_first (cmp_first),
        .ray_id    (ray_id),
        .greater   (greater),
        .cmp_ready (cmp_ready),
        .hit_valid (hit_valid),
        .hit       (hit),
        .hit_id    (hit_id),
        .hit_ready (hit_ready),
        .err       (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    function automatic void modelReset();
        exp_q.delete();
        m_active = 1'b0;
        m_err    = 1'b0;
        m_acc    = 1'b0;
        m_cnt    = 0;
    endfunction

    // A ray's verdict is "hit" when none of its NCMP overlap tests came back greater.
    function automatic void modelIssue(input bit first, input logic [7:0] id, input bit g, input bit ready);
        if (first) begin
            if (!ready || m_active) m_err = 1'b1;
            m_active = 1'b1;
            m_id     = id;
            m_acc    = g;
            m_cnt    = 1;
        end else if (!m_active) begin
            m_err = 1'b1;
        end else begin
            m_acc = m_acc | g;
            m_cnt++;
        end
        if (m_active && m_cnt == NCMP) begin
            exp_q.push_back({m_id, ~m_acc});
            m_active = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input bit iss, input bit first, input logic [7:0] id, input bit g);
        cmp_issue = iss;
        cmp_first = iss & first;
        ray_id    = iss ? id : 8'($urandom);
        greater   = gl[LAT-1];
        gl        = {gl[LAT-2:0], iss ? g : 1'($urandom)};
        if (rand_mode) hit_ready = 1'($urandom_range(0, 1));
        if (iss && rst) modelIssue(first, id, g, cmp_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Every handshake is checked against the model queue; err may never lead the model.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("err_ahead_of_model", {31'd0, err & ~m_err}, 32'd0);
            if (hit_valid && hit_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL pop_unexpected: got id %0h hit %0b, expected none", hit_id, hit);
                end else begin
                    checkOutput("pop_data", {23'd0, hit_id, hit}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        logic [7:0] rid;
        modelReset();

        // Reset with random inputs.
        rst = 1'b0;
        repeat (5) begin
            cmp_issue = 1'($urandom);
            cmp_first = 1'($urandom);
            ray_id    = 8'($urandom);
            greater   = 1'($urandom);
            hit_ready = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("rst_hit_valid", {31'd0, hit_valid}, 32'd0);
        checkOutput("rst_hit_id", {24'd0, hit_id}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_cmp_ready", {31'd0, cmp_ready}, 32'd0);
        cmp_issue = 1'b0;
        cmp_first = 1'b0;
        greater   = 1'b0;
        hit_ready = 1'b0;
        gl        = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rel_cmp_ready", {31'd0, cmp_ready}, 32'd1);

        // Single hit, consecutive compares.
        for (int i = 0; i < NCMP; i++) applyStimulus(1'b1, i == 0, 8'h05, 1'b0);
        idle(3);
        checkOutput("t2_valid_early", {31'd0, hit_valid}, 32'd0);
        idle(1);
        checkOutput("t2_valid", {31'd0, hit_valid}, 32'd1);
        checkOutput("t2_hit", {31'd0, hit}, 32'd1);
        checkOutput("t2_id", {24'd0, hit_id}, 32'h05);
        checkOutput("t2_model", {23'd0, exp_q[0]}, {23'd0, 8'h05, 1'b1});
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;

        // Miss with idle gaps inside the ray.
        for (int i = 0; i < NCMP; i++) begin
            applyStimulus(1'b1, i == 0, 8'h06, i == 3);
            if (i == 2 || i == 5) idle(1);
        end
        idle(5);
        checkOutput("t3_valid", {31'd0, hit_valid}, 32'd1);
        checkOutput("t3_hit", {31'd0, hit}, 32'd0);
        checkOutput("t3_id", {24'd0, hit_id}, 32'h06);
        checkOutput("t3_err", {31'd0, err}, 32'd0);
        checkOutput("t3_model", {23'd0, exp_q[0]}, {23'd0, 8'h06, 1'b0});
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;

        // Backpressure: four rays fill every credit.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NCMP; i++) begin
                applyStimulus(1'b1, i == 0, 8'(8'h10 + r), (r == 1) && (i == 7));
                if (i == 0 && r == 2) checkOutput("t4_ready_3rd", {31'd0, cmp_ready}, 32'd1);
                if (i == 0 && r == 3) checkOutput("t4_ready_4th", {31'd0, cmp_ready}, 32'd0);
            end
        end
        idle(5);
        checkOutput("t4_ready_full", {31'd0, cmp_ready}, 32'd0);
        checkOutput("t4_head_id", {24'd0, hit_id}, 32'h10);
        checkOutput("t4_model_cnt", exp_q.size(), 32'd4);
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;
        checkOutput("t4_ready_after_pop", {31'd0, cmp_ready}, 32'd1);
        checkOutput("t4_model_next", {23'd0, exp_q[0]}, {23'd0, 8'h11, 1'b0});
        checkOutput("t4_model_last", {23'd0, exp_q[2]}, {23'd0, 8'h13, 1'b1});
        hit_ready = 1'b1;
        idle(4);
        hit_ready = 1'b0;
        checkOutput("t4_drained", {31'd0, hit_valid}, 32'd0);

        // Protocol error: ray 0x07 is abandoned by a new first on its 5th compare.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, 8'h07, 1'b0);
        for (int i = 0; i < NCMP; i++) applyStimulus(1'b1, i == 0, 8'h08, 1'b0);
        idle(5);
        checkOutput("t5_err", {31'd0, err}, 32'd1);
        checkOutput("t5_id", {24'd0, hit_id}, 32'h08);
        checkOutput("t5_model_cnt", exp_q.size(), 32'd1);
        hit_ready = 1'b1;
        idle(2);
        hit_ready = 1'b0;
        checkOutput("t5_drained", {31'd0, hit_valid}, 32'd0);
        checkOutput("t5_ready", {31'd0, cmp_ready}, 32'd1);

        // Reset during the 6th compare of ray 0x09.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, 8'h09, 1'b1);
        cmp_issue = 1'b1;
        cmp_first = 1'b0;
        ray_id    = 8'h09;
        #2;
        rst = 1'b0;
        modelReset();
        gl = '0;
        idle(2);
        checkOutput("t6_valid", {31'd0, hit_valid}, 32'd0);
        checkOutput("t6_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        idle(1);
        checkOutput("t6_ready", {31'd0, cmp_ready}, 32'd1);
        for (int i = 0; i < NCMP; i++) applyStimulus(1'b1, i == 0, 8'h0A, i == 1);
        idle(5);
        checkOutput("t6_id", {24'd0, hit_id}, 32'h0A);
        checkOutput("t6_hit", {31'd0, hit}, 32'd0);
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;

        // Randomized rays with random gaps and random consumer stalls.
        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            w = 0;
            while (!cmp_ready && w < 200) begin
                idle(1);
                w++;
            end
            if (w >= 200) failNow("ready_timeout");
            rid = 8'($urandom);
            for (int i = 0; i < NCMP; i++) begin
                applyStimulus(1'b1, i == 0, rid, $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
        end
        rand_mode = 1'b0;
        hit_ready = 1'b1;
        w = 0;
        while ((exp_q.size() != 0 || hit_valid) && w < 300) begin
            idle(1);
            w++;
        end
        if (w >= 300) failNow("drain_timeout");
        idle(2);
        checkOutput("end_queue_empty", exp_q.size(), 32'd0);
        checkOutput("end_err", {31'd0, err}, {31'd0, m_err});
        checkOutput("end_ready", {31'd0, cmp_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
